hilo_multiplier: RTL
====================

# hilo_multiplier

Sequential unsigned multiplier with the architectural HI/LO register pair for the MIPS datapath. It sits beside the ALU in the execute stage and feeds the execute-stage result select.

- Accepts MULTU on a start pulse and iterates shift-add over WIDTH cycles.
- Commits the 2·WIDTH-bit product to HI/LO.
- Drives HI or LO onto its result output for MFHI/MFLO, so the result select can pick it in place of the per-bit ALU output.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- funct  input  6  instruction funct field
- dataA  input  WIDTH  multiplicand (rs)
- dataB  input  WIDTH  multiplier (rt)
- busy  output  1  high while an operation is iterating
- done  output  1  one-cycle pulse after HI/LO commit
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO
- dataOut  output  WIDTH  combinational read port: HI for MFHI, LO for MFLO, else 0

## Operation
Funct codes:
- MULTU = 6'b011001
- MFHI = 6'b010000
- MFLO = 6'b010010
- All other funct values: no multiplier action; dataOut = 0.

States (IDLE, RUN, DONE):
- IDLE:
  - start && funct==MULTU → latch dataA into the multiplicand register and dataB into the low half of a 2·WIDTH-bit accumulator; clear the upper half and the iteration counter; go to RUN.
  - start with any other funct is ignored.
- RUN, one iteration per clock:
  - If acc[0]=1, add the multiplicand to acc[2W-1:W] with a WIDTH+1-bit sum (carry retained).
  - Shift the {carry, acc} right by one; counter += 1.
  - After iteration WIDTH: hi ← acc[2W-1:W], lo ← acc[W-1:0]; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start with MULTU in DONE is accepted exactly as from IDLE (back-to-back).

Rules:
- start while in RUN is ignored; the operation in flight is unaffected.
- hi/lo hold their previous values throughout RUN and change only on the commit edge. MFHI/MFLO during busy return the old values; stalling dependent instructions is the hazard unit's job.
- dataOut is purely combinational on funct, hi and lo, valid in every state.
- The product is exact: no overflow, no sign handling.
- rst, in any state including mid-RUN: next state IDLE, hi=lo=0, accumulator and counter cleared, no done pulse.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0; dataOut=0 unless funct selects HI/LO (which read 0).
- Accept edge E0: busy=1 from E0 through E_WIDTH.
- Edges E1..E_WIDTH perform the WIDTH iterations.
- After E_WIDTH: hi/lo hold the product, busy=0, done=1 for that one cycle only.
- Latency from the accept edge to the HI/LO commit: WIDTH cycles. Issue interval: WIDTH+1 cycles (via DONE-state accept).
- Simultaneous rst and start: rst wins; nothing is accepted.

## Structure
Shared package hilo_pkg holds:
- FUNCT_MULTU, FUNCT_MFHI, FUNCT_MFLO;
- the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).

The ALU control and the result select import the same funct constants. The block stays flat: one FSM, one WIDTH+1-bit adder, one counter of $clog2(WIDTH)+1 bits. No sub-module.

## Test plan
- Reset: assert rst 2 cycles → busy=0, done=0, hi=lo=0; with funct=MFHI or MFLO, dataOut=0.
- Small product: MULTU 3×5 → accept at E0, done at E32, lo=0x0000000F, hi=0. Then funct=MFLO gives dataOut=0x0000000F; funct=MFHI gives 0.
- Max operands: MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 32 cycles; done high exactly 1 cycle.
- Start handling:
  - start MULTU 7×9 at cycle 10 of a 2×2 op → ignored; result lo=4.
  - start MULTU 7×9 in the DONE cycle → accepted; lo=63 after another 32 cycles.
- Reset mid-op: rst at iteration 10 of 0x12345678×0x9ABCDEF0 → IDLE next cycle, hi=lo=0, no done pulse; a subsequent MULTU 2×3 completes normally with lo=6.
- Non-multiply start: start with funct=6'b100000 (ADD) → stays IDLE, busy=0, hi/lo unchanged.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared MIPS multiply/divide-unit constants: funct codes and multiplier FSM state encoding.
package hilo_pkg;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_multiplier.sv
// Sequential shift-add unsigned multiplier owning the architectural HI/LO pair,
// with a combinational MFHI/MFLO read port for the execute-stage result select.
module hilo_multiplier
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] dataOut
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;
  logic [WIDTH:0]     sum;
  logic               accept;

  assign accept = start && (funct == FUNCT_MULTU);

  // One iteration: conditional add into the upper half keeping the carry, then shift right.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (accept) begin
            mcand_q <= dataA;
            acc_q   <= {{WIDTH{1'b0}}, dataB};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            hi_q    <= acc_d[2*WIDTH-1:WIDTH];
            lo_q    <= acc_d[WIDTH-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    dataOut = '0;
    case (funct)
      FUNCT_MFHI: dataOut = hi_q;
      FUNCT_MFLO: dataOut = lo_q;
      default:    dataOut = '0;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
